// File: rtl/i2c_slave_responder.sv
`timescale 1ns/1ps
// i2c_slave_responder
// Responder side of a single-master I2C link. sclk and sda_in are oversampled
// on the system clock; START/STOP framing, 7-bit address match with ACK, a
// receive path handing bytes to the user and a transmit path shifting out
// user-supplied bytes. SDA is split into sda_in (wire) and sda_out (0 = pull low).
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h5A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       sda_in,
    output logic       sda_out,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack_en,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy,
    output logic       rd_mode,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_ADDR_ACK = 4'd2,
        ST_RX_BYTE  = 4'd3,
        ST_RX_ACK   = 4'd4,
        ST_TX_BYTE  = 4'd5,
        ST_TX_ACK   = 4'd6
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nxt;
    // Set when a byte (or the address, or the master's ACK) has completed on a
    // rise; the action it triggers happens on the following scl fall.
    logic       r_pend;
    logic       w_pend_nxt;
    logic       r_sda_out;
    logic       w_sda_nxt;
    logic [7:0] r_rx_data;
    logic [7:0] w_rx_data_nxt;
    logic       r_rx_valid;
    logic       w_rx_valid_nxt;
    logic       r_busy;
    logic       w_busy_nxt;
    logic       r_rd_mode;
    logic       w_rd_mode_nxt;
    logic       w_tx_req;

    logic       w_s_scl;
    logic       w_s_sda;
    logic       w_rise;
    logic       w_fall;
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_byte;

    assign w_s_scl = r_scl_sync[SYNC_STAGES-1];
    assign w_s_sda = r_sda_sync[SYNC_STAGES-1];
    assign w_rise  = w_s_scl & ~r_scl_prev;
    assign w_fall  = ~w_s_scl & r_scl_prev;
    assign w_start = w_s_scl & r_sda_prev & ~w_s_sda;
    assign w_stop  = w_s_scl & ~r_sda_prev & w_s_sda;
    assign w_byte  = {r_shift[6:0], w_s_sda};

    assign sda_out  = r_sda_out;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_req   = w_tx_req;
    assign busy     = r_busy;
    assign rd_mode  = r_rd_mode;
    assign state    = r_state;

    // Synchronize the bus pins and keep one-sample history for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], sclk};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_prev <= w_s_scl;
            r_sda_prev <= w_s_sda;
        end
    end

    // FSM state and control registers; reset releases SDA immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 3'd0;
            r_pend     <= 1'b0;
            r_sda_out  <= 1'b1;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_rd_mode  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pend     <= w_pend_nxt;
            r_sda_out  <= w_sda_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_busy     <= w_busy_nxt;
            r_rd_mode  <= w_rd_mode_nxt;
        end
    end

    // Shift register is pure datapath; its content is always rewritten before use.
    always_ff @(posedge clk) begin
        r_shift <= w_shift_nxt;
    end

    // Next-state and output decode; START/STOP override whatever state is active.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_shift_nxt    = r_shift;
        w_pend_nxt     = r_pend;
        w_sda_nxt      = r_sda_out;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = 1'b0;
        w_busy_nxt     = r_busy;
        w_rd_mode_nxt  = r_rd_mode;
        w_tx_req       = 1'b0;

        if (w_stop) begin
            w_state_nxt = ST_IDLE;
            w_sda_nxt   = 1'b1;
            w_busy_nxt  = 1'b0;
            w_pend_nxt  = 1'b0;
            w_cnt_nxt   = 3'd0;
        end else if (w_start) begin
            w_state_nxt = ST_ADDR;
            w_sda_nxt   = 1'b1;
            w_pend_nxt  = 1'b0;
            w_cnt_nxt   = 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_sda_nxt = 1'b1;
                end
                ST_ADDR: begin
                    if (w_rise && !r_pend) begin
                        w_shift_nxt = w_byte;
                        w_cnt_nxt   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            if (w_byte[7:1] == SLAVE_ADDR) begin
                                w_rd_mode_nxt = w_byte[0];
                                w_busy_nxt    = 1'b1;
                                w_pend_nxt    = 1'b1;
                            end else begin
                                w_state_nxt = ST_IDLE;
                                w_busy_nxt  = 1'b0;
                            end
                        end
                    end else if (w_fall && r_pend) begin
                        w_sda_nxt   = 1'b0;
                        w_pend_nxt  = 1'b0;
                        w_state_nxt = ST_ADDR_ACK;
                    end
                end
                ST_ADDR_ACK: begin
                    if (w_fall) begin
                        w_cnt_nxt = 3'd0;
                        if (r_rd_mode) begin
                            w_tx_req    = 1'b1;
                            w_shift_nxt = tx_data;
                            w_sda_nxt   = tx_data[7];
                            w_state_nxt = ST_TX_BYTE;
                        end else begin
                            w_sda_nxt   = 1'b1;
                            w_state_nxt = ST_RX_BYTE;
                        end
                    end
                end
                ST_RX_BYTE: begin
                    if (w_rise && !r_pend) begin
                        w_shift_nxt = w_byte;
                        w_cnt_nxt   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_rx_data_nxt  = w_byte;
                            w_rx_valid_nxt = 1'b1;
                            w_pend_nxt     = 1'b1;
                        end
                    end else if (w_fall && r_pend) begin
                        w_sda_nxt   = ~rx_ack_en;
                        w_pend_nxt  = 1'b0;
                        w_state_nxt = ST_RX_ACK;
                    end
                end
                ST_RX_ACK: begin
                    if (w_fall) begin
                        w_sda_nxt   = 1'b1;
                        w_cnt_nxt   = 3'd0;
                        w_state_nxt = ST_RX_BYTE;
                    end
                end
                ST_TX_BYTE: begin
                    // MSB went out on entry; falls 1..7 drive bits 6..0, fall 8 releases.
                    if (w_fall) begin
                        if (r_cnt == 3'd7) begin
                            w_sda_nxt   = 1'b1;
                            w_cnt_nxt   = 3'd0;
                            w_state_nxt = ST_TX_ACK;
                        end else begin
                            w_shift_nxt = {r_shift[6:0], 1'b0};
                            w_sda_nxt   = r_shift[6];
                            w_cnt_nxt   = r_cnt + 3'd1;
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (w_rise && !r_pend) begin
                        if (!w_s_sda) begin
                            w_pend_nxt = 1'b1;
                        end else begin
                            w_sda_nxt   = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end else if (w_fall && r_pend) begin
                        w_pend_nxt  = 1'b0;
                        w_tx_req    = 1'b1;
                        w_shift_nxt = tx_data;
                        w_sda_nxt   = tx_data[7];
                        w_cnt_nxt   = 3'd0;
                        w_state_nxt = ST_TX_BYTE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_sda_nxt   = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_slave_responder.sv
`timescale 1ns/1ps
// tb_i2c_slave_responder
// Bit-banged I2C master against the responder, with a scoreboard of expected
// received bytes and expected wire bits on reads.
module tb_i2c_slave_responder;

    localparam time Q = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b1;
    logic       m_sda = 1'b1;
    logic       rx_ack_en = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_out;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic       busy;
    logic       rd_mode;
    logic [3:0] state;
    wire        w_bus;

    assign w_bus = m_sda & sda_out;

    int checks = 0;
    int errors = 0;
    int rx_cnt = 0;
    int txreq_cnt = 0;
    int sda_low_cnt = 0;
    logic rx_prev = 1'b0;
    logic tx_prev = 1'b0;
    logic [7:0] mon_exp;

    logic [7:0] q_rx[$];
    logic       q_bits[$];

    always #5 clk = ~clk;

    i2c_slave_responder #(.SLAVE_ADDR(7'h5A), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .sda_in(w_bus), .sda_out(sda_out),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack_en(rx_ack_en),
        .tx_data(tx_data), .tx_req(tx_req), .busy(busy), .rd_mode(rd_mode),
        .state(state)
    );

    // Output monitor: pops expected rx bytes, counts pulses and SDA-low cycles.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (sda_out === 1'b0) sda_low_cnt++;
            if (rx_valid === 1'b1) begin
                rx_cnt++;
                checks++;
                if (q_rx.size() == 0) begin
                    errors++;
                    $display("FAIL rx_unexpected got %h want no pulse", rx_data);
                end else begin
                    mon_exp = q_rx.pop_front();
                    if (rx_data !== mon_exp) begin
                        errors++;
                        $display("FAIL rx_data got %h want %h", rx_data, mon_exp);
                    end
                end
                checks++;
                if (rx_prev === 1'b1 || tx_req === 1'b1) begin
                    errors++;
                    $display("FAIL rx_valid_pulse got prev=%b tx_req=%b want 0 0", rx_prev, tx_req);
                end
            end
            if (tx_req === 1'b1) begin
                txreq_cnt++;
                checks++;
                if (tx_prev === 1'b1) begin
                    errors++;
                    $display("FAIL tx_req_width got 2+ cycles want 1");
                end
            end
            rx_prev <= rx_valid;
            tx_prev <= tx_req;
        end
    end

    // SDA must never be pulled low while the clock line is high.
    always @(negedge sda_out) begin
        if (rst === 1'b0) begin
            checks++;
            if (sclk !== 1'b0) begin
                errors++;
                $display("FAIL sda_fall_scl_high got sclk=%b want 0", sclk);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    task automatic bus_start();
        m_sda = 1'b1; sclk = 1'b1;
        #Q m_sda = 1'b0;
        #Q sclk = 1'b0;
    endtask

    task automatic bus_rstart();
        #Q m_sda = 1'b1;
        #Q sclk = 1'b1;
        #Q m_sda = 1'b0;
        #Q sclk = 1'b0;
    endtask

    task automatic bus_stop();
        #Q m_sda = 1'b0;
        #Q sclk = 1'b1;
        #Q m_sda = 1'b1;
        #Q;
    endtask

    task automatic send_bit(input logic b);
        #Q m_sda = b;
        #Q sclk = 1'b1;
        #Q;
        #Q sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
    endtask

    task automatic read_bit(output logic b);
        #Q m_sda = 1'b1;
        #Q sclk = 1'b1;
        #Q b = w_bus;
        #Q sclk = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({sda_out, rx_data, rx_valid, tx_req, busy, rd_mode, state} !== {1'b1, 8'h00, 4'b0000, 4'd0}) begin
            errors++;
            $display("FAIL reset_outputs got sda=%b rx=%h v=%b tq=%b busy=%b rd=%b st=%0d want 1 00 0 0 0 0 0",
                     sda_out, rx_data, rx_valid, tx_req, busy, rd_mode, state);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write_ack();
        logic a;
        int r0;
        r0 = rx_cnt;
        bus_start();
        send_byte(8'hB4);
        read_bit(a);
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL t1_addr_ack got %b want 0", a); end
        checks++;
        if (busy !== 1'b1 || rd_mode !== 1'b0) begin
            errors++; $display("FAIL t1_busy_rd got %b%b want 10", busy, rd_mode);
        end
        q_rx.push_back(8'hC3);
        send_byte(8'hC3);
        read_bit(a);
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL t1_data_ack got %b want 0", a); end
        bus_stop();
        checks++;
        if (busy !== 1'b0 || state !== 4'd0) begin
            errors++; $display("FAIL t1_stop got busy=%b st=%0d want 0 0", busy, state);
        end
        checks++;
        if (rx_data !== 8'hC3 || rx_cnt - r0 != 1) begin
            errors++; $display("FAIL t1_rx got %h x%0d want c3 x1", rx_data, rx_cnt - r0);
        end
    endtask

    task automatic test_addr_mismatch();
        logic a;
        int r0, l0;
        r0 = rx_cnt;
        l0 = sda_low_cnt;
        bus_start();
        send_byte(8'hB6);
        read_bit(a);
        checks++;
        if (a !== 1'b1) begin errors++; $display("FAIL t2_addr_nack got %b want 1", a); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL t2_busy got %b want 0", busy); end
        send_byte(8'h00);
        read_bit(a);
        checks++;
        if (a !== 1'b1) begin errors++; $display("FAIL t2_data_nack got %b want 1", a); end
        bus_stop();
        checks++;
        if (sda_low_cnt != l0 || rx_cnt != r0) begin
            errors++; $display("FAIL t2_silent got low=%0d rx=%0d want 0 0", sda_low_cnt - l0, rx_cnt - r0);
        end
    endtask

    task automatic test_read();
        logic a, b, e;
        int t0;
        t0 = txreq_cnt;
        tx_data = 8'hA6;
        for (int i = 7; i >= 0; i--) q_bits.push_back(tx_data[i]);
        bus_start();
        send_byte(8'hB5);
        read_bit(a);
        checks++;
        if (a !== 1'b0 || rd_mode !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL t3_addr got ack=%b rd=%b busy=%b want 0 1 1", a, rd_mode, busy);
        end
        for (int byte_i = 0; byte_i < 2; byte_i++) begin
            for (int i = 0; i < 8; i++) begin
                read_bit(b);
                checks++;
                if (q_bits.size() == 0) begin
                    errors++; $display("FAIL t3_bit_underflow got %b want none", b);
                end else begin
                    e = q_bits.pop_front();
                    if (b !== e) begin
                        errors++; $display("FAIL t3_bit byte%0d bit%0d got %b want %b", byte_i, 7 - i, b, e);
                    end
                end
            end
            if (byte_i == 0) begin
                tx_data = 8'h3C;
                for (int i = 7; i >= 0; i--) q_bits.push_back(tx_data[i]);
                send_bit(1'b0);
            end else begin
                send_bit(1'b1);
            end
        end
        repeat (2) @(negedge clk);
        checks++;
        if (sda_out !== 1'b1 || state !== 4'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL t3_after_nack got sda=%b st=%0d busy=%b want 1 0 1", sda_out, state, busy);
        end
        bus_stop();
        checks++;
        if (busy !== 1'b0 || txreq_cnt - t0 != 2) begin
            errors++; $display("FAIL t3_end got busy=%b tx_req=%0d want 0 2", busy, txreq_cnt - t0);
        end
    endtask

    task automatic test_rx_nack();
        logic a;
        int r0;
        r0 = rx_cnt;
        rx_ack_en = 1'b0;
        bus_start();
        send_byte(8'hB4);
        read_bit(a);
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL t4_addr_ack got %b want 0", a); end
        q_rx.push_back(8'h11);
        send_byte(8'h11);
        read_bit(a);
        checks++;
        if (a !== 1'b1) begin errors++; $display("FAIL t4_data_nack got %b want 1", a); end
        bus_stop();
        checks++;
        if (rx_cnt - r0 != 1 || rx_data !== 8'h11) begin
            errors++; $display("FAIL t4_rx got %h x%0d want 11 x1", rx_data, rx_cnt - r0);
        end
        rx_ack_en = 1'b1;
    endtask

    task automatic test_repeated_start();
        logic a;
        bus_start();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        bus_rstart();
        send_byte(8'hB4);
        read_bit(a);
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL t5_addr_ack got %b want 0", a); end
        q_rx.push_back(8'h7E);
        send_byte(8'h7E);
        read_bit(a);
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL t5_data_ack got %b want 0", a); end
        bus_stop();
        checks++;
        if (rx_data !== 8'h7E || state !== 4'd0) begin
            errors++; $display("FAIL t5_end got rx=%h st=%0d want 7e 0", rx_data, state);
        end
    endtask

    task automatic test_reset_mid_tx();
        logic a;
        tx_data = 8'h3F;
        bus_start();
        send_byte(8'hB5);
        read_bit(a);
        repeat (6) @(negedge clk);
        checks++;
        if (a !== 1'b0 || sda_out !== 1'b0 || state !== 4'd5) begin
            errors++; $display("FAIL t6_pre got ack=%b sda=%b st=%0d want 0 0 5", a, sda_out, state);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (sda_out !== 1'b1 || state !== 4'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL t6_rst got sda=%b st=%0d busy=%b want 1 0 0", sda_out, state, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #Q sclk = 1'b1;
        #Q;
        bus_start();
        send_byte(8'hB4);
        read_bit(a);
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL t6_addr_ack got %b want 0", a); end
        q_rx.push_back(8'h5C);
        send_byte(8'h5C);
        read_bit(a);
        bus_stop();
        checks++;
        if (a !== 1'b0 || rx_data !== 8'h5C || busy !== 1'b0) begin
            errors++; $display("FAIL t6_after got ack=%b rx=%h busy=%b want 0 5c 0", a, rx_data, busy);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_write_ack();
        test_addr_mismatch();
        test_read();
        test_rx_nack();
        test_repeated_start();
        test_reset_mid_tx();
        repeat (4) @(negedge clk);
        checks++;
        if (q_rx.size() != 0 || q_bits.size() != 0) begin
            errors++; $display("FAIL leftover got rx=%0d bits=%0d want 0 0", q_rx.size(), q_bits.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
